// File: rtl/nv_fifo_ctrl_64x512.sv
// 64-entry x 512-bit FIFO controller driving an external registered-address RAM.
// Define NV_FIFO_CTRL_64X512_COUNT_EN to expose the occupancy on wr_count.
module nv_fifo_ctrl_64x512 #(
  parameter int unsigned WR_LIMIT = 64
) (
  input  logic         nvdla_core_clk,
  input  logic         nvdla_core_rstn,
  input  logic         wr_pvld,
  output logic         wr_prdy,
  input  logic [511:0] wr_pd,
  output logic         rd_pvld,
  input  logic         rd_prdy,
  output logic [511:0] rd_pd,
  output logic [5:0]   ram_wa,
  output logic         ram_we,
  output logic [511:0] ram_di,
  output logic [5:0]   ram_ra,
  output logic         ram_re,
  input  logic [511:0] ram_dout,
  input  logic [31:0]  pwrbus_ram_pd,
  output logic [31:0]  ram_pwrbus_ram_pd,
  output logic [6:0]   wr_count
);

  localparam logic [6:0] Limit = 7'(WR_LIMIT);

  logic [5:0] wr_ptr_q, wr_ptr_d;
  logic [5:0] rd_ptr_q, rd_ptr_d;
  logic [6:0] count_q, count_d;
  logic [6:0] unread_q, unread_d;
  logic       rd_pvld_q, rd_pvld_d;
  logic       wr_prdy_q, wr_prdy_d;
  logic       push, pop, fetch;

  assign push  = wr_pvld & wr_prdy_q;
  assign pop   = rd_pvld_q & rd_prdy;
  // Prefetch into the RAM's address register whenever the output slot is free or being freed.
  assign fetch = (unread_q != 7'd0) & (~rd_pvld_q | rd_prdy);

  always_comb begin
    wr_ptr_d  = wr_ptr_q + 6'(push);
    rd_ptr_d  = rd_ptr_q + 6'(fetch);
    count_d   = count_q + 7'(push) - 7'(pop);
    unread_d  = unread_q + 7'(push) - 7'(fetch);
    rd_pvld_d = rd_pvld_q;
    if (fetch) begin
      rd_pvld_d = 1'b1;
    end else if (pop) begin
      rd_pvld_d = 1'b0;
    end
    // Ready is computed from the post-update count, so a pop while full does not pass through.
    wr_prdy_d = (count_d < Limit);
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q  <= 6'd0;
      rd_ptr_q  <= 6'd0;
      count_q   <= 7'd0;
      unread_q  <= 7'd0;
      rd_pvld_q <= 1'b0;
      wr_prdy_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      unread_q  <= unread_d;
      rd_pvld_q <= rd_pvld_d;
      wr_prdy_q <= wr_prdy_d;
    end
  end

  assign wr_prdy           = wr_prdy_q;
  assign rd_pvld           = rd_pvld_q;
  assign rd_pd             = ram_dout;
  assign ram_we            = push;
  assign ram_wa            = wr_ptr_q;
  assign ram_di            = wr_pd;
  assign ram_re            = fetch;
  assign ram_ra            = rd_ptr_q;
  assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

`ifdef NV_FIFO_CTRL_64X512_COUNT_EN
  assign wr_count = count_q;
`else
  assign wr_count = 7'd0;
`endif

endmodule

// File: tb/tb_nv_fifo_ctrl_64x512.sv
// Self-checking bench for nv_fifo_ctrl_64x512: directed steps plus randomized traffic
// checked against a queue-based FIFO model.
module tb_nv_fifo_ctrl_64x512;

`ifdef NV_FIFO_CTRL_64X512_COUNT_EN
  localparam bit CountEn = 1'b1;
`else
  localparam bit CountEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rstn;
  logic [31:0]  pwr;
  // DUT A (default limit)
  logic         wr_pvld, wr_prdy, rd_pvld, rd_prdy, ram_we, ram_re;
  logic [511:0] wr_pd, rd_pd, ram_di, ram_dout;
  logic [5:0]   ram_wa, ram_ra;
  logic [31:0]  pwr_out;
  logic [6:0]   wr_count;
  // DUT B (limit 4)
  logic         wr_pvld_b, wr_prdy_b, rd_pvld_b, rd_prdy_b, ram_we_b, ram_re_b;
  logic [511:0] wr_pd_b, rd_pd_b, ram_di_b, ram_dout_b;
  logic [5:0]   ram_wa_b, ram_ra_b;
  logic [31:0]  pwr_out_b;
  logic [6:0]   wr_count_b;

  always #5 clk = ~clk;

  nv_fifo_ctrl_64x512 u_dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
    .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
    .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
    .ram_ra(ram_ra), .ram_re(ram_re), .ram_dout(ram_dout),
    .pwrbus_ram_pd(pwr), .ram_pwrbus_ram_pd(pwr_out), .wr_count(wr_count)
  );

  nv_fifo_ctrl_64x512 #(.WR_LIMIT(4)) u_dut_b (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .wr_pvld(wr_pvld_b), .wr_prdy(wr_prdy_b), .wr_pd(wr_pd_b),
    .rd_pvld(rd_pvld_b), .rd_prdy(rd_prdy_b), .rd_pd(rd_pd_b),
    .ram_wa(ram_wa_b), .ram_we(ram_we_b), .ram_di(ram_di_b),
    .ram_ra(ram_ra_b), .ram_re(ram_re_b), .ram_dout(ram_dout_b),
    .pwrbus_ram_pd(pwr), .ram_pwrbus_ram_pd(pwr_out_b), .wr_count(wr_count_b)
  );

  // RAM models: registered read address, combinational data out.
  logic [511:0] mem_a [64];
  logic [511:0] mem_b [64];
  logic [5:0]   ra_a, ra_b;
  always @(posedge clk) begin
    if (ram_we) mem_a[ram_wa] <= ram_di;
    if (ram_re) ra_a <= ram_ra;
    if (ram_we_b) mem_b[ram_wa_b] <= ram_di_b;
    if (ram_re_b) ra_b <= ram_ra_b;
  end
  assign ram_dout   = mem_a[ra_a];
  assign ram_dout_b = mem_b[ra_b];

  int           checks = 0;
  int           errors = 0;
  int           n_push = 0;
  logic [511:0] q [$];
  logic         rdy_ok = 1'b0;
  logic         stalled = 1'b0;
  logic [511:0] stall_pd;

  function automatic logic [6:0] ecnt(int n);
    return CountEn ? 7'(n) : 7'd0;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(string tag, logic [511:0] obs, logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the FIFO is the queue of entries pushed and not yet popped.
  task automatic sb();
    logic [511:0] exp_pd;
    if (!rstn) begin
      q.delete();
      stalled = 1'b0;
      chk1("rst_wr_prdy", wr_prdy, 1'b0);
      chk1("rst_rd_pvld", rd_pvld, 1'b0);
      chk1("rst_ram_we", ram_we, 1'b0);
      chk1("rst_ram_re", ram_re, 1'b0);
      chkw("rst_wr_count", 512'(wr_count), 512'(0));
      return;
    end
    chk1("wr_prdy", wr_prdy, rdy_ok && (q.size() < 64));
    chkw("wr_count", 512'(wr_count), 512'(ecnt(q.size())));
    if (stalled) begin
      chk1("stall_vld", rd_pvld, 1'b1);
      chkw("stall_pd", rd_pd, stall_pd);
    end
    if (rd_pvld && rd_prdy) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL spurious_pop observed=pop expected=no_pop");
      end
      if (q.size() != 0) begin
        exp_pd = q.pop_front();
        chkw("order", rd_pd, exp_pd);
      end
    end
    stalled  = rd_pvld && !rd_prdy;
    stall_pd = rd_pd;
    if (wr_pvld && wr_prdy) begin
      q.push_back(wr_pd);
      n_push++;
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
  task automatic tick();
    @(negedge clk);
    sb();
    @(posedge clk);
    rdy_ok = rstn;
    #1;
  endtask

  task automatic drain();
    wr_pvld = 1'b0;
    rd_prdy = 1'b1;
    for (int k = 0; k < 200 && q.size() != 0; k++) tick();
    tick();
    tick();
    chkw("drain_left", 512'(q.size()), 512'(0));
    chk1("drain_vld", rd_pvld, 1'b0);
  endtask

  initial begin
    logic [511:0] v;
    logic [511:0] first_b;
    int           acc;
    int           start;
    rstn = 1'b0;
    pwr = $urandom;
    wr_pvld = 1'b0; wr_pd = '0; rd_prdy = 1'b0;
    wr_pvld_b = 1'b0; wr_pd_b = '0; rd_prdy_b = 1'b0;
    #1;
    repeat (3) tick();
    chkw("pwrbus_a", 512'(pwr_out), 512'(pwr));
    chkw("pwrbus_b", 512'(pwr_out_b), 512'(pwr));
    rstn = 1'b1;
    chk1("rdy_low_at_release", wr_prdy, 1'b0);
    tick();
    chk1("rdy_after_rst", wr_prdy, 1'b1);

    // Single entry latency
    v = {16{32'hA5A5A5A5}};
    wr_pvld = 1'b1; wr_pd = v; rd_prdy = 1'b1;
    tick();
    wr_pvld = 1'b0;
    chk1("lat_c1_vld", rd_pvld, 1'b0);
    chkw("lat_c1_cnt", 512'(wr_count), 512'(ecnt(1)));
    tick();
    chk1("lat_c2_vld", rd_pvld, 1'b1);
    chkw("lat_c2_pd", rd_pd, v);
    tick();
    chk1("lat_c3_vld", rd_pvld, 1'b0);
    chkw("lat_c3_cnt", 512'(wr_count), 512'(ecnt(0)));

    // WR_LIMIT=4 instance: six back-to-back pushes
    acc = 0;
    first_b = rand512();
    for (int i = 0; i < 6; i++) begin
      wr_pvld_b = 1'b1;
      wr_pd_b = (i == 0) ? first_b : rand512();
      if (wr_prdy_b) acc++;
      tick();
    end
    wr_pvld_b = 1'b0;
    chkw("lim4_accepted", 512'(acc), 512'(4));
    chk1("lim4_rdy", wr_prdy_b, 1'b0);
    chkw("lim4_cnt", 512'(wr_count_b), 512'(ecnt(4)));
    chk1("lim4_vld", rd_pvld_b, 1'b1);
    chkw("lim4_pd", rd_pd_b, first_b);

    // Fill to 64 with the index in bits 5:0
    rd_prdy = 1'b0;
    for (int i = 0; i < 64; i++) begin
      v = rand512();
      v[5:0] = 6'(i);
      wr_pvld = 1'b1; wr_pd = v;
      chk1("fill_rdy", wr_prdy, 1'b1);
      tick();
    end
    chk1("full_rdy", wr_prdy, 1'b0);
    chkw("full_cnt", 512'(wr_count), 512'(ecnt(64)));
    chk1("full_vld", rd_pvld, 1'b1);
    wr_pd = rand512();
    #1;
    chk1("full_no_we", ram_we, 1'b0);
    tick();
    rd_prdy = 1'b1;
    #1;
    chk1("full_pop_no_we", ram_we, 1'b0);
    tick();
    rd_prdy = 1'b0;
    chk1("pop_rdy_next", wr_prdy, 1'b1);
    chkw("pop_cnt", 512'(wr_count), 512'(ecnt(63)));
    tick();
    drain();

    // Random traffic with stalls, crossing the pointer wrap several times
    start = n_push;
    for (int k = 0; k < 3000 && (n_push - start) < 200; k++) begin
      wr_pvld = ($urandom_range(0, 3) != 0);
      wr_pd = rand512();
      rd_prdy = ($urandom_range(0, 9) < 6);
      tick();
    end
    chk1("rand_push_budget", (n_push - start) >= 200, 1'b1);
    drain();

    // Full-rate streaming
    for (int k = 0; k < 130; k++) begin
      wr_pvld = 1'b1; wr_pd = rand512(); rd_prdy = 1'b1;
      if (k >= 2) begin
        chk1("stream_vld", rd_pvld, 1'b1);
        chkw("stream_cnt", 512'(wr_count), 512'(ecnt(2)));
      end
      tick();
    end
    drain();

    // Reset with 10 entries held
    rd_prdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_pvld = 1'b1; wr_pd = rand512();
      tick();
    end
    wr_pvld = 1'b0;
    rstn = 1'b0;
    #1;
    chk1("mid_rst_vld", rd_pvld, 1'b0);
    chk1("mid_rst_rdy", wr_prdy, 1'b0);
    chkw("mid_rst_cnt", 512'(wr_count), 512'(0));
    tick();
    tick();
    rstn = 1'b1;
    tick();
    v = rand512();
    wr_pvld = 1'b1; wr_pd = v; rd_prdy = 1'b1;
    tick();
    wr_pvld = 1'b0;
    for (int k = 0; k < 10 && !rd_pvld; k++) tick();
    chk1("post_rst_vld", rd_pvld, 1'b1);
    chkw("post_rst_pd", rd_pd, v);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
